// File: rtl/alu_pkg.sv
// Shared ALU encodings: opcode classes, R-type funct codes, FSM states, PSR flag bit indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Opcode class lives in alu_opcode[7:4]
  localparam logic [3:0] CLS_RTYPE = 4'b0000;
  localparam logic [3:0] CLS_SHIFT = 4'b1000;
  localparam logic [3:0] CLS_LUI   = 4'b1111;

  // R-type funct lives in alu_opcode[3:0]
  localparam logic [3:0] FN_AND  = 4'b0001;
  localparam logic [3:0] FN_OR   = 4'b0010;
  localparam logic [3:0] FN_XOR  = 4'b0011;
  localparam logic [3:0] FN_ADD  = 4'b0101;
  localparam logic [3:0] FN_ADDU = 4'b0110;
  localparam logic [3:0] FN_ADDC = 4'b0111;
  localparam logic [3:0] FN_SUB  = 4'b1001;
  localparam logic [3:0] FN_SUBC = 4'b1010;
  localparam logic [3:0] FN_CMP  = 4'b1011;
  localparam logic [3:0] FN_MOV  = 4'b1101;
  localparam logic [3:0] FN_MUL  = 4'b1110;

  // Shift opcode bit selecting sign fill on right shifts
  localparam int SHIFT_ARITH_BIT = 1;

  // PSR flag vector is {C,L,F,Z,N}
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Magnitude of a 5-bit two's-complement shift amount; -16 maps to 16.
  function automatic logic [5:0] shift_mag(input logic [4:0] amt);
    logic [5:0] sext;
    sext = {amt[4], amt};
    shift_mag = amt[4] ? (6'd0 - sext) : sext;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between opcode translator, execute stage and writeback.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operation side, out_valid/out_ready on the result side.
// Ports: in_valid, in_ready, alu_opcode[7:0], op_a, op_b, out_valid, out_ready, result, flags[4:0].
interface alu_exec_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       alu_opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  // Upstream/writeback side
  modport master (
    output in_valid, alu_opcode, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // Execute stage side
  modport slave (
    input  in_valid, alu_opcode, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter holding the working register and remaining count.
// Latency: amt cycles after start; done is high during the final shift step.
// Backpressure: none; the owning FSM only starts it when idle.
// Ports: clock, reset (async active-low), start, data, amt (magnitude), dir_right, arith,
//        done, shifted (working register after one more step).
module alu_shift_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [5:0]       amt,
  input  logic             dir_right,
  input  logic             arith,
  output logic             done,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] work;
  logic [5:0]       cnt;
  logic             right_q;
  logic             arith_q;

  // Sign fill only for arithmetic right shifts; left shifts always fill with zero.
  assign shifted = right_q ? {arith_q & work[WIDTH-1], work[WIDTH-1:1]}
                           : {work[WIDTH-2:0], 1'b0};

  // The step taken while cnt==1 produces the final value.
  assign done = (cnt == 6'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      work    <= '0;
      cnt     <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (start) begin
      work    <= data;
      cnt     <= amt;
      right_q <= dir_right;
      arith_q <= arith;
    end else if (cnt != 6'd0) begin
      work <= shifted;
      cnt  <= cnt - 6'd1;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: accepts one ALU op, computes result and PSR flags, holds them for writeback.
// Latency: 1 cycle accept->out_valid; shifts 1+|k| cycles.
// Backpressure: result held until out_ready; in_ready only when idle and the output slot drains.
// Ports: clock, reset (async active-low), bus (alu_exec_stage_if.slave).
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int         WIDTH    = 16,
  parameter logic [4:0] FLAG_RST = 5'b00000
) (
  input logic             clock,
  input logic             reset,
  alu_exec_stage_if.slave bus
);

  localparam logic [5:0] WSAT = 6'(WIDTH);

  state_t           state;
  logic             out_valid;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       cls;
  logic [3:0]       funct;
  logic             in_ready;
  logic             accept;
  logic [5:0]       amt_abs;
  logic [5:0]       amt_sat;
  logic             shift_start;
  logic             shift_done;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res_c;
  logic [4:0]       flags_c;

  assign a     = bus.op_a;
  assign b     = bus.op_b;
  assign cls   = bus.alu_opcode[7:4];
  assign funct = bus.alu_opcode[3:0];

  // Gated by reset so nothing is offered upstream while reset is held.
  assign in_ready = reset & (state == IDLE) & (~out_valid | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  assign amt_abs     = shift_mag(b[4:0]);
  assign amt_sat     = (amt_abs > WSAT) ? WSAT : amt_abs;
  // Zero-amount shifts complete like any single-cycle op (result = op_a).
  assign shift_start = accept & (cls == CLS_SHIFT) & (amt_sat != 6'd0);

  assign mul_lo = a * b;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clock     (clock),
    .reset     (reset),
    .start     (shift_start),
    .data      (a),
    .amt       (amt_sat),
    .dir_right (b[4]),
    .arith     (bus.alu_opcode[SHIFT_ARITH_BIT]),
    .done      (shift_done),
    .shifted   (shift_res)
  );

  // Single-cycle ops. Unlisted opcodes pass op_a through with flags untouched.
  always_comb begin
    res_c   = a;
    flags_c = flags_q;
    ext     = '0;
    case (cls)
      CLS_RTYPE: begin
        case (funct)
          FN_AND: res_c = a & b;
          FN_OR:  res_c = a | b;
          FN_XOR: res_c = a ^ b;
          FN_ADD: begin
            ext             = {1'b0, a} + {1'b0, b};
            res_c           = ext[WIDTH-1:0];
            flags_c[FLAG_C] = ext[WIDTH];
            flags_c[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
          end
          FN_ADDU: begin
            ext             = {1'b0, a} + {1'b0, b};
            res_c           = ext[WIDTH-1:0];
            flags_c[FLAG_C] = ext[WIDTH];
          end
          FN_ADDC: begin
            ext             = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flags_q[FLAG_C]};
            res_c           = ext[WIDTH-1:0];
            flags_c[FLAG_C] = ext[WIDTH];
          end
          FN_SUB: begin
            // Bit WIDTH of the extended difference is the borrow.
            ext             = {1'b0, a} - {1'b0, b};
            res_c           = ext[WIDTH-1:0];
            flags_c[FLAG_C] = ext[WIDTH];
            flags_c[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
          end
          FN_SUBC: begin
            ext             = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, flags_q[FLAG_C]};
            res_c           = ext[WIDTH-1:0];
            flags_c[FLAG_C] = ext[WIDTH];
          end
          FN_CMP: begin
            flags_c[FLAG_Z] = (a == b);
            flags_c[FLAG_L] = (a < b);
            flags_c[FLAG_N] = ($signed(a) < $signed(b));
          end
          FN_MOV: res_c = b;
          FN_MUL: res_c = mul_lo;
          default: ;
        endcase
      end
      CLS_LUI: res_c = {b[7:0], {(WIDTH-8){1'b0}}};
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result_q  <= '0;
      flags_q   <= FLAG_RST;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (shift_start) begin
              // Slot was empty or draining this cycle, so nothing is lost.
              state     <= SHIFT;
              out_valid <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              result_q  <= res_c;
              flags_q   <= flags_c;
            end
          end else if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            result_q  <= shift_res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a result/flags scoreboard popped on each writeback transfer.
module tb_alu_exec_stage;
  logic clock = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   w;
  logic [20:0] exp_q[$];

  always #5 clock = ~clock;

  alu_exec_stage_if #(.WIDTH(16)) bus ();

  alu_exec_stage #(.WIDTH(16), .FLAG_RST(5'b00000)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input string tag, input logic [7:0] opc, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] er, input logic [4:0] ef,
                      input bit push, output int waits);
    bit accepted;
    bus.alu_opcode = opc;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.in_valid   = 1'b1;
    if (push) exp_q.push_back({er, ef});
    waits    = 0;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (bus.in_ready === 1'b1) accepted = 1'b1;
      else waits++;
    end
    chk({tag, "_accept"}, 32'(accepted), 32'd1);
    @(posedge clock);
    #1;
    bus.in_valid   = 1'b0;
    bus.alu_opcode = 8'h05;
    bus.op_a       = 16'hDEAD;
    bus.op_b       = 16'hDEAD;
  endtask

  // Scoreboard: compare on every writeback transfer.
  always @(negedge clock) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [20:0] e;
        e = exp_q.pop_front();
        chk("sb_result", 32'(bus.result), 32'(e[20:5]));
        chk("sb_flags", 32'(bus.flags), 32'(e[4:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.alu_opcode = 8'h00;
    bus.op_a       = 16'h0000;
    bus.op_b       = 16'h0000;
    bus.out_ready  = 1'b1;

    @(negedge clock);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // ADD signed overflow, single-cycle latency
    send("add", 8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1, w);
    @(negedge clock);
    chk("add_latency", 32'(bus.out_valid), 32'd1);
    step();

    // ADDU carry out, then ADDC back-to-back consuming that carry
    send("addu", 8'h06, 16'hFFFF, 16'h0002, 16'h0001, 5'b10100, 1, w);
    send("addc", 8'h07, 16'h0001, 16'h0001, 16'h0003, 5'b00100, 1, w);
    chk("addc_b2b_waits", 32'(w), 32'd0);

    // Logical right shift by 4 (op_b[4:0] = -4)
    send("lsh", 8'h80, 16'h8001, 16'h001C, 16'h0800, 5'b00100, 1, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("lsh_busy_out_valid", 32'(bus.out_valid), 32'd0);
      chk("lsh_busy_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clock);
    chk("lsh_done", 32'(bus.out_valid), 32'd1);
    step();

    send("ash", 8'h82, 16'h8001, 16'h001C, 16'hF800, 5'b00100, 1, w);
    send("sub", 8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'b10000, 1, w);
    send("cmp", 8'h0B, 16'h0001, 16'hFFFF, 16'h0001, 5'b11000, 1, w);
    step();

    // Writeback stalls: MOV result held, no new op accepted
    bus.out_ready = 1'b0;
    send("mov", 8'h0D, 16'hAAAA, 16'h1234, 16'h1234, 5'b11000, 1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", 32'(bus.result), 32'h1234);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    step();
    bus.out_ready = 1'b1;
    send("lui", 8'hF0, 16'h0000, 16'h00AB, 16'hAB00, 5'b11000, 1, w);
    chk("drain_accept_same_cycle", 32'(w), 32'd0);

    send("unknown", 8'h40, 16'h5555, 16'h0000, 16'h5555, 5'b11000, 1, w);
    send("shift0", 8'h80, 16'hBEEF, 16'h0020, 16'hBEEF, 5'b11000, 1, w);
    @(negedge clock);
    chk("shift0_latency", 32'(bus.out_valid), 32'd1);
    step();
    send("ash16", 8'h82, 16'h8000, 16'h0010, 16'hFFFF, 5'b11000, 1, w);

    // Reset two cycles into an 8-bit shift: op abandoned
    send("lsh8", 8'h80, 16'h0001, 16'h0008, 16'h0000, 5'b00000, 0, w);
    step(); step();
    rst_n = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_flags", 32'(bus.flags), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("abandoned_out_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    send("and", 8'h01, 16'h0F0F, 16'h00FF, 16'h000F, 5'b00000, 1, w);
    send("xor", 8'h03, 16'hFF00, 16'h0FF0, 16'hF0F0, 5'b00000, 1, w);
    send("or", 8'h02, 16'h1200, 16'h0034, 16'h1234, 5'b00000, 1, w);
    send("mul", 8'h0E, 16'h1234, 16'h0010, 16'h2340, 5'b00000, 1, w);
    send("sub2", 8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'b10000, 1, w);
    send("subc", 8'h0A, 16'h0005, 16'h0003, 16'h0001, 5'b00000, 1, w);

    step(); step(); step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
